swd_target_responder: RTL and testbench

SWD_TARGET_RESPONDER -- requirements
Module: swd_target_responder

---
 rtl/swd_target_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_swd_target_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/swd_target_responder.sv
// SWD target-side wire protocol engine: oversamples SWCLK/SWDIO on CLK, decodes
// requests, drives ACK/read data and presents register accesses downstream.
module swd_target_responder #(
   parameter int SYNC_STAGES    = 2,  // must be at least 2
   parameter int LINE_RESET_LEN = 50
) (
   input  logic        CLK,
   input  logic        PORESET,
   input  logic        SWCLKTCK,
   input  logic        SWDITMS,
   output logic        SWDO,
   output logic        SWDOEN,
   output logic        REG_VALID,
   output logic        REG_APNDP,
   output logic        REG_RNW,
   output logic [1:0]  REG_ADDR,
   output logic [31:0] REG_WDATA,
   input  logic [31:0] REG_RDATA,
   input  logic        REG_WAIT,
   output logic        WDERR,
   output logic [3:0]  DBG_STATE
);

   localparam int CW = $clog2(LINE_RESET_LEN + 1);

   localparam logic [2:0] ACK_OK    = 3'b001;
   localparam logic [2:0] ACK_WAIT  = 3'b010;
   localparam logic [2:0] ACK_FAULT = 3'b100;

   typedef enum logic [3:0] {
      S_LOCKOUT = 4'd0,
      S_IDLE    = 4'd1,
      S_REQ     = 4'd2,
      S_TRN1    = 4'd3,
      S_ACK     = 4'd4,
      S_RDATA   = 4'd5,
      S_TRN2    = 4'd6,
      S_TRNW    = 4'd7,
      S_WDATA   = 4'd8
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] swclk_sync;
   logic [SYNC_STAGES-1:0] swdio_sync;
   logic                   swclk_prev;
   logic                   swclktckedge;
   logic                   din;
   logic [CW-1:0]          lr_cnt;
   logic [CW-1:0]          lr_cnt_next;
   logic                   lr_hit;
   logic [5:0]             bit_cnt;
   logic [5:0]             req_sr;
   logic [6:0]             req_full;
   logic                   req_ok;
   logic [2:0]             ack_sel;
   logic [2:0]             ack_sr;
   logic                   ack_is_ok;
   logic                   dp_ctrl;
   logic [31:0]            rd_sr;
   logic                   wpar;

   assign DBG_STATE = state;

   always_ff @(posedge CLK) begin
      if (PORESET) begin
         swclk_sync <= '0;
         swdio_sync <= '0;
         swclk_prev <= 1'b0;
      end else begin
         swclk_sync <= {swclk_sync[SYNC_STAGES-2:0], SWCLKTCK};
         swdio_sync <= {swdio_sync[SYNC_STAGES-2:0], SWDITMS};
         swclk_prev <= swclk_sync[SYNC_STAGES-1];
      end
   end

   assign swclktckedge = swclk_sync[SYNC_STAGES-1] & ~swclk_prev;
   assign din          = swdio_sync[SYNC_STAGES-1];

   // Ones only count toward a line reset while the host owns the wire.
   always_comb begin
      lr_cnt_next = lr_cnt;
      if (!din) begin
         lr_cnt_next = '0;
      end else if (!SWDOEN && (lr_cnt != CW'(LINE_RESET_LEN))) begin
         lr_cnt_next = lr_cnt + 1'b1;
      end
   end

   assign lr_hit   = (lr_cnt_next == CW'(LINE_RESET_LEN));
   assign req_full = {din, req_sr};
   assign req_ok   = (req_full[4] == ^req_full[3:0]) && !req_full[5] && req_full[6];
   assign dp_ctrl  = !REG_APNDP && (REG_ADDR == 2'b00);

   always_comb begin
      ack_sel = ACK_OK;
      if (dp_ctrl)       ack_sel = ACK_OK;
      else if (WDERR)    ack_sel = ACK_FAULT;
      else if (REG_WAIT) ack_sel = ACK_WAIT;
   end

   // Downstream handshake: REG_VALID is a one-CLK strobe with no ready; the only
   // backpressure is REG_WAIT, sampled when the ACK is chosen, and a WAIT/FAULT
   // ACK suppresses the strobe entirely.
   always_ff @(posedge CLK) begin
      if (PORESET) begin
         state     <= S_LOCKOUT;
         lr_cnt    <= '0;
         SWDO      <= 1'b0;
         SWDOEN    <= 1'b0;
         REG_VALID <= 1'b0;
         REG_APNDP <= 1'b0;
         REG_RNW   <= 1'b0;
         REG_ADDR  <= 2'b00;
         REG_WDATA <= 32'h0;
         WDERR     <= 1'b0;
         bit_cnt   <= 6'd0;
         req_sr    <= 6'd0;
         ack_sr    <= 3'b000;
         ack_is_ok <= 1'b0;
         rd_sr     <= 32'h0;
         wpar      <= 1'b0;
      end else begin
         REG_VALID <= 1'b0;
         if (swclktckedge) begin
            lr_cnt <= lr_cnt_next;
            if (lr_hit) begin
               state  <= S_LOCKOUT;
               SWDOEN <= 1'b0;
               SWDO   <= 1'b0;
            end else begin
               case (state)
                  S_LOCKOUT: begin
                     if (!din && (lr_cnt == CW'(LINE_RESET_LEN))) state <= S_IDLE;
                  end
                  S_IDLE: begin
                     if (din) begin
                        state   <= S_REQ;
                        bit_cnt <= 6'd0;
                     end
                  end
                  S_REQ: begin
                     req_sr  <= req_full[6:1];
                     bit_cnt <= bit_cnt + 6'd1;
                     if (bit_cnt == 6'd6) begin
                        if (req_ok) begin
                           state     <= S_TRN1;
                           REG_APNDP <= req_full[0];
                           REG_RNW   <= req_full[1];
                           REG_ADDR  <= req_full[3:2];
                        end else begin
                           state <= S_LOCKOUT;
                        end
                     end
                  end
                  S_TRN1: begin
                     state     <= S_ACK;
                     SWDOEN    <= 1'b1;
                     SWDO      <= ack_sel[0];
                     ack_sr    <= {1'b0, ack_sel[2:1]};
                     ack_is_ok <= (ack_sel == ACK_OK);
                     bit_cnt   <= 6'd1;
                     if ((ack_sel == ACK_OK) && REG_RNW) REG_VALID <= 1'b1;
                  end
                  S_ACK: begin
                     if (bit_cnt != 6'd3) begin
                        SWDO    <= ack_sr[0];
                        ack_sr  <= {1'b0, ack_sr[2:1]};
                        bit_cnt <= bit_cnt + 6'd1;
                     end else if (!ack_is_ok) begin
                        state  <= S_TRN2;
                        SWDOEN <= 1'b0;
                        SWDO   <= 1'b0;
                     end else if (REG_RNW) begin
                        // Read data is captured here, the first edge of the data phase.
                        state   <= S_RDATA;
                        SWDO    <= REG_RDATA[0];
                        rd_sr   <= {^REG_RDATA, REG_RDATA[31:1]};
                        bit_cnt <= 6'd0;
                     end else begin
                        state  <= S_TRNW;
                        SWDOEN <= 1'b0;
                        SWDO   <= 1'b0;
                     end
                  end
                  S_RDATA: begin
                     if (bit_cnt == 6'd32) begin
                        state  <= S_TRN2;
                        SWDOEN <= 1'b0;
                        SWDO   <= 1'b0;
                     end else begin
                        SWDO    <= rd_sr[0];
                        rd_sr   <= {1'b0, rd_sr[31:1]};
                        bit_cnt <= bit_cnt + 6'd1;
                     end
                  end
                  S_TRN2: begin
                     state <= S_IDLE;
                  end
                  S_TRNW: begin
                     state   <= S_WDATA;
                     bit_cnt <= 6'd0;
                     wpar    <= 1'b0;
                  end
                  S_WDATA: begin
                     if (bit_cnt != 6'd32) begin
                        REG_WDATA <= {din, REG_WDATA[31:1]};
                        wpar      <= wpar ^ din;
                        bit_cnt   <= bit_cnt + 6'd1;
                     end else begin
                        state <= S_IDLE;
                        if (din == wpar) begin
                           REG_VALID <= 1'b1;
                           if (dp_ctrl && REG_WDATA[3]) WDERR <= 1'b0;
                        end else begin
                           WDERR <= 1'b1;
                        end
                     end
                  end
                  default: begin
                     state  <= S_LOCKOUT;
                     SWDOEN <= 1'b0;
                     SWDO   <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_swd_target_responder.sv
// Directed bench for swd_target_responder: bit-bangs SWD transactions through an
// emulated pad and checks ACK, data, strobes and error flags against hand values.
module tb_swd_target_responder;

   localparam logic [3:0] ST_LOCKOUT = 4'd0;
   localparam logic [3:0] ST_IDLE    = 4'd1;
   localparam logic [3:0] ST_TRN1    = 4'd3;
   localparam logic [3:0] ST_TRN2    = 4'd6;
   localparam logic [3:0] ST_TRNW    = 4'd7;
   localparam logic [3:0] ST_WDATA   = 4'd8;

   // Request bytes, bit 0 is the start bit sent first.
   localparam logic [7:0] RQ_DP_RD_A0  = 8'hA5;
   localparam logic [7:0] RQ_DP_RD_BAD = 8'h85;
   localparam logic [7:0] RQ_AP_WR_A1  = 8'h8B;
   localparam logic [7:0] RQ_AP_RD_A0  = 8'h87;
   localparam logic [7:0] RQ_AP_WR_A2  = 8'h93;
   localparam logic [7:0] RQ_DP_WR_A0  = 8'h81;

   logic        CLK = 1'b0;
   logic        PORESET;
   logic        SWCLKTCK;
   logic        SWDITMS;
   logic        SWDO;
   logic        SWDOEN;
   logic        REG_VALID;
   logic        REG_APNDP;
   logic        REG_RNW;
   logic [1:0]  REG_ADDR;
   logic [31:0] REG_WDATA;
   logic [31:0] REG_RDATA;
   logic        REG_WAIT;
   logic        WDERR;
   logic [3:0]  DBG_STATE;
   logic        host_drv;

   int          checks = 0;
   int          failures = 0;
   int          valid_cnt = 0;
   int          v0;
   logic [31:0] cap_wdata;
   logic        cap_apndp, cap_rnw, cap_wderr;
   logic [1:0]  cap_addr;
   logic [63:0] vec;
   logic        oen_all, seen_a, seen_b;

   swd_target_responder dut (
      .CLK       (CLK),
      .PORESET   (PORESET),
      .SWCLKTCK  (SWCLKTCK),
      .SWDITMS   (SWDITMS),
      .SWDO      (SWDO),
      .SWDOEN    (SWDOEN),
      .REG_VALID (REG_VALID),
      .REG_APNDP (REG_APNDP),
      .REG_RNW   (REG_RNW),
      .REG_ADDR  (REG_ADDR),
      .REG_WDATA (REG_WDATA),
      .REG_RDATA (REG_RDATA),
      .REG_WAIT  (REG_WAIT),
      .WDERR     (WDERR),
      .DBG_STATE (DBG_STATE)
   );

   always #5 CLK = ~CLK;

   // Pad model: the target wins whenever it enables its driver.
   assign SWDITMS = SWDOEN ? SWDO : host_drv;

   always @(negedge CLK) begin
      if (REG_VALID === 1'b1) begin
         valid_cnt = valid_cnt + 1;
         cap_wdata = REG_WDATA;
         cap_apndp = REG_APNDP;
         cap_rnw   = REG_RNW;
         cap_addr  = REG_ADDR;
         cap_wderr = WDERR;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One SWCLK period of 8 CLKs; outputs of this edge are settled on return.
   task automatic swd_bit(input logic b);
      @(negedge CLK);
      host_drv = b;
      repeat (3) @(negedge CLK);
      SWCLKTCK = 1'b1;
      repeat (4) @(negedge CLK);
      SWCLKTCK = 1'b0;
   endtask

   task automatic send_bits(input logic [63:0] v, input int n, output logic seen_oen);
      seen_oen = 1'b0;
      for (int i = 0; i < n; i++) begin
         swd_bit(v[i]);
         seen_oen = seen_oen | SWDOEN;
      end
   endtask

   task automatic target_bits(input int n, output logic [63:0] v, output logic all_oen);
      v = '0;
      all_oen = 1'b1;
      for (int i = 0; i < n; i++) begin
         swd_bit(1'b0);
         v[i] = SWDO;
         all_oen = all_oen & SWDOEN;
      end
   endtask

   task automatic line_reset();
      logic s;
      send_bits(64'hFFFF_FFFF_FFFF_FFFF, 50, s);
      send_bits(64'h0, 2, s);
   endtask

   initial begin
      PORESET   = 1'b1;
      SWCLKTCK  = 1'b0;
      host_drv  = 1'b0;
      REG_RDATA = 32'h0;
      REG_WAIT  = 1'b0;
      repeat (4) @(negedge CLK);
      check("reset_oen",   32'(SWDOEN), 32'd0);
      check("reset_do",    32'(SWDO), 32'd0);
      check("reset_state", 32'(DBG_STATE), 32'(ST_LOCKOUT));
      check("reset_valid", 32'(REG_VALID), 32'd0);
      check("reset_wderr", 32'(WDERR), 32'd0);
      check("reset_addr",  32'({REG_APNDP, REG_RNW, REG_ADDR}), 32'd0);
      check("reset_wdata", REG_WDATA, 32'h0);
      PORESET = 1'b0;

      // A request before any line reset must be ignored.
      send_bits(64'(RQ_DP_RD_A0), 8, seen_a);
      send_bits(64'h0, 6, seen_b);
      check("nolr_oen",   32'(seen_a | seen_b), 32'd0);
      check("nolr_valid", 32'(valid_cnt), 32'd0);
      check("nolr_state", 32'(DBG_STATE), 32'(ST_LOCKOUT));

      // 49 ones is one short of a line reset.
      send_bits(64'hFFFF_FFFF_FFFF_FFFF, 49, seen_a);
      send_bits(64'h0, 1, seen_a);
      check("lr49_state", 32'(DBG_STATE), 32'(ST_LOCKOUT));
      send_bits(64'hFFFF_FFFF_FFFF_FFFF, 50, seen_a);
      check("lr50_state", 32'(DBG_STATE), 32'(ST_LOCKOUT));
      send_bits(64'h0, 2, seen_a);
      check("lr_idle", 32'(DBG_STATE), 32'(ST_IDLE));

      // DP read A=0; 0x0BB11477 has 15 ones so its even-parity bit is 1.
      REG_RDATA = 32'h0BB1_1477;
      v0 = valid_cnt;
      send_bits(64'(RQ_DP_RD_A0), 8, seen_a);
      check("rd_trn1", 32'(DBG_STATE), 32'(ST_TRN1));
      target_bits(36, vec, oen_all);
      check("rd_ack",  32'(vec[2:0]), 32'b001);
      check("rd_data", vec[34:3], 32'h0BB1_1477);
      check("rd_par",  32'(vec[35]), 32'd1);
      check("rd_oen",  32'(oen_all), 32'd1);
      swd_bit(1'b0);
      check("rd_trn2_oen",   32'(SWDOEN), 32'd0);
      check("rd_trn2_state", 32'(DBG_STATE), 32'(ST_TRN2));
      swd_bit(1'b0);
      check("rd_idle",  32'(DBG_STATE), 32'(ST_IDLE));
      check("rd_valid", 32'(valid_cnt - v0), 32'd1);
      check("rd_fields", 32'({cap_apndp, cap_rnw, cap_addr}), 32'b0100);

      // AP write A=1, 0xDEADBEEF (24 ones, parity 0).
      v0 = valid_cnt;
      send_bits(64'(RQ_AP_WR_A1), 8, seen_a);
      target_bits(3, vec, oen_all);
      check("wr_ack", 32'(vec[2:0]), 32'b001);
      swd_bit(1'b0);
      check("wr_trnw_oen",   32'(SWDOEN), 32'd0);
      check("wr_trnw_state", 32'(DBG_STATE), 32'(ST_TRNW));
      swd_bit(1'b0);
      check("wr_wdata_state", 32'(DBG_STATE), 32'(ST_WDATA));
      send_bits({31'd0, 1'b0, 32'hDEAD_BEEF}, 33, seen_a);
      check("wr_valid",  32'(valid_cnt - v0), 32'd1);
      check("wr_data",   cap_wdata, 32'hDEAD_BEEF);
      check("wr_fields", 32'({cap_apndp, cap_rnw, cap_addr}), 32'b1001);
      check("wr_wderr",  32'(WDERR), 32'd0);
      check("wr_idle",   32'(DBG_STATE), 32'(ST_IDLE));

      // AP read while downstream busy.
      REG_WAIT = 1'b1;
      v0 = valid_cnt;
      send_bits(64'(RQ_AP_RD_A0), 8, seen_a);
      target_bits(3, vec, oen_all);
      check("wait_ack", 32'(vec[2:0]), 32'b010);
      check("wait_ack_oen", 32'(oen_all), 32'd1);
      swd_bit(1'b0);
      check("wait_oen_after", 32'(SWDOEN), 32'd0);
      check("wait_trn2", 32'(DBG_STATE), 32'(ST_TRN2));
      swd_bit(1'b0);
      check("wait_valid", 32'(valid_cnt - v0), 32'd0);
      REG_WAIT = 1'b0;

      // AP write A=2, 0x12345678 (13 ones) sent with parity 0: a parity error.
      v0 = valid_cnt;
      send_bits(64'(RQ_AP_WR_A2), 8, seen_a);
      target_bits(3, vec, oen_all);
      check("bp_ack", 32'(vec[2:0]), 32'b001);
      swd_bit(1'b0);
      swd_bit(1'b0);
      send_bits({31'd0, 1'b0, 32'h1234_5678}, 33, seen_a);
      check("bp_wderr", 32'(WDERR), 32'd1);
      check("bp_valid", 32'(valid_cnt - v0), 32'd0);
      check("bp_idle",  32'(DBG_STATE), 32'(ST_IDLE));

      // Sticky error faults the next AP access.
      send_bits(64'(RQ_AP_RD_A0), 8, seen_a);
      target_bits(3, vec, oen_all);
      check("fault_ack", 32'(vec[2:0]), 32'b100);
      swd_bit(1'b0);
      check("fault_oen_after", 32'(SWDOEN), 32'd0);
      swd_bit(1'b0);
      check("fault_valid", 32'(valid_cnt - v0), 32'd0);

      // DP write A=0 gets OK despite WDERR and REG_WAIT; data bit 3 clears WDERR.
      REG_WAIT = 1'b1;
      send_bits(64'(RQ_DP_WR_A0), 8, seen_a);
      target_bits(3, vec, oen_all);
      check("clr_ack", 32'(vec[2:0]), 32'b001);
      swd_bit(1'b0);
      swd_bit(1'b0);
      send_bits({31'd0, 1'b1, 32'h0000_0008}, 33, seen_a);
      check("clr_valid",     32'(valid_cnt - v0), 32'd1);
      check("clr_data",      cap_wdata, 32'h0000_0008);
      check("clr_wderr_cyc", 32'(cap_wderr), 32'd0);
      check("clr_wderr",     32'(WDERR), 32'd0);
      REG_WAIT = 1'b0;

      // Request parity error locks the target out until a line reset.
      v0 = valid_cnt;
      send_bits(64'(RQ_DP_RD_BAD), 8, seen_a);
      check("badreq_state", 32'(DBG_STATE), 32'(ST_LOCKOUT));
      send_bits(64'(RQ_DP_RD_A0), 8, seen_b);
      check("badreq_oen", 32'(seen_a | seen_b), 32'd0);
      send_bits(64'h0, 8, seen_b);
      check("badreq_oen2",  32'(seen_b), 32'd0);
      check("badreq_valid", 32'(valid_cnt - v0), 32'd0);
      line_reset();
      check("badreq_recover", 32'(DBG_STATE), 32'(ST_IDLE));
      REG_RDATA = 32'hA5A5_0F0F;
      send_bits(64'(RQ_DP_RD_A0), 8, seen_a);
      target_bits(36, vec, oen_all);
      check("rd2_ack",  32'(vec[2:0]), 32'b001);
      check("rd2_data", vec[34:3], 32'hA5A5_0F0F);
      check("rd2_par",  32'(vec[35]), 32'd0);
      swd_bit(1'b0);
      swd_bit(1'b0);

      // PORESET while data bit 10 (a 1) is on the wire.
      REG_RDATA = 32'hCAFE_F40D;
      send_bits(64'(RQ_DP_RD_A0), 8, seen_a);
      target_bits(14, vec, oen_all);
      check("por_pre_oen", 32'(SWDOEN), 32'd1);
      check("por_pre_bit10", 32'(SWDO), 32'd1);
      @(negedge CLK);
      PORESET = 1'b1;
      @(negedge CLK);
      check("por_oen",   32'(SWDOEN), 32'd0);
      check("por_do",    32'(SWDO), 32'd0);
      check("por_state", 32'(DBG_STATE), 32'(ST_LOCKOUT));
      PORESET = 1'b0;
      repeat (2) @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
